// File: rtl/led_arbiter_if.sv
// Display bus between the frame sources and the LED arbiter: requests,
// frames and frame tick in; grant, LED drive and busy out.
interface led_arbiter_if;
  logic        fc;
  logic [3:0]  req;
  logic [63:0] frames;
  logic [3:0]  gnt;
  logic [15:0] led;
  logic        busy;

  modport master (output fc, req, frames, input gnt, led, busy);
  modport slave  (input fc, req, frames, output gnt, led, busy);
endinterface

// File: rtl/led_arbiter.sv
// Round-robin LED display arbiter for four frame sources with a minimum
// hold time measured in frame ticks.
// Optional feature: define PRIORITY_PREEMPT_EN to let source 0 take the
// display from any other owner immediately, regardless of hold time.
module led_arbiter #(
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input logic         clk,
  input logic         rst,
  led_arbiter_if.slave bus
);

  localparam int unsigned LED_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_FRAMES);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic [1:0]       own;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       gnt_q;
  logic [LED_W-1:0] led_q;
  logic             busy_q;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       expired;
  logic       other_req;
  logic       do_grant;
  logic [1:0] grant_idx;
  logic       go_idle;
  logic       cnt_inc;

  assign bus.gnt  = gnt_q;
  assign bus.led  = led_q;
  assign bus.busy = busy_q;

  assign expired   = (hold_cnt == HOLD_MAX);
  assign other_req = |(bus.req & ~(4'b0001 << own));

  // Round-robin search starting one past the last winner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    scan_idx = ptr;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = 2'(int'(ptr) + k);
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Arbitration decision for the coming edge.
  always_comb begin
    do_grant  = 1'b0;
    grant_idx = pick_idx;
    go_idle   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: do_grant = pick_vld;
      OWN: begin
`ifdef PRIORITY_PREEMPT_EN
        if (bus.req[0] && (own != 2'd0)) begin
          do_grant  = 1'b1;
          grant_idx = 2'd0;
        end else
`endif
        if (!bus.req[own]) begin
          // Owner dropped: the old owner cannot win since its req is low.
          do_grant = pick_vld;
          go_idle  = !pick_vld;
        end else if (expired && other_req) begin
          // Owner sits last in the search order, so a different source wins.
          do_grant = 1'b1;
        end else begin
          cnt_inc = bus.fc && !expired;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // State, ownership, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      own      <= 2'd0;
      ptr      <= 2'd3;
      hold_cnt <= '0;
      gnt_q    <= 4'b0000;
      led_q    <= IDLE_PATTERN;
      busy_q   <= 1'b0;
    end else begin
      led_q <= (state == OWN) ? bus.frames[{own, 4'b0000} +: LED_W] : IDLE_PATTERN;
      if (do_grant) begin
        state    <= OWN;
        own      <= grant_idx;
        ptr      <= grant_idx;
        hold_cnt <= '0;
        gnt_q    <= 4'b0001 << grant_idx;
        busy_q   <= 1'b1;
      end else if (go_idle) begin
        state    <= IDLE;
        hold_cnt <= '0;
        gnt_q    <= 4'b0000;
        busy_q   <= 1'b0;
      end else if (cnt_inc) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule
